// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
// operand_sequencer
//   Sweeps every operand pair (i, j) in 0..LIMIT-1 into a downstream adder,
//   waits SETTLE cycles, then checks the returned sum and counts errors.
//   Revision: 1.0
// ============================================================================
module operand_sequencer #(
  parameter int WIDTH  = 4,
  parameter int LIMIT  = 10,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             mismatch,
  output logic [7:0]       err_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // One spare bit so i can step past 2^WIDTH-1 after the final pair.
  localparam logic [WIDTH:0] LAST     = (WIDTH+1)'(LIMIT - 1);
  localparam logic [3:0]     SETTLE_C = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [WIDTH:0]   i_q, i_d;
  logic [WIDTH:0]   j_q, j_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] sum;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    settle_d   = settle_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    done_d     = 1'b0;
    sum        = a_q + b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          err_d   = 8'd0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_DRIVE: begin
        a_d      = i_q[WIDTH-1:0];
        b_d      = j_q[WIDTH-1:0];
        settle_d = SETTLE_C;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (c != sum) begin
          mismatch_d = 1'b1;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
        if (j_q < LAST) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end
        if (i_q == LAST && j_q == LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      settle_q   <= 4'd0;
      err_q      <= 8'd0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
// tb_operand_sequencer
//   Three sequencer instances (default, LIMIT=1/SETTLE=3, LIMIT=16/SETTLE=2)
//   checked every cycle against a timeline model of the sweep.
//   Revision: 1.0
// ============================================================================
module tb_operand_sequencer;

  localparam int NI = 3;
  localparam int LIM [NI] = '{10, 1, 16};
  localparam int SET [NI] = '{1, 3, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] c_i    [NI];
  logic [3:0] a_o    [NI];
  logic [3:0] b_o    [NI];
  logic       busy_o [NI];
  logic       mis_o  [NI];
  logic [7:0] err_o  [NI];
  logic       done_o [NI];

  int mode   = 0;
  bit cmp_en = 1'b0;
  int n_cmp  = 0;
  int n_bad  = 0;

  // Model state: m_d counts edges since the start was accepted.
  bit m_act  [NI] = '{0, 0, 0};
  int m_d    [NI] = '{0, 0, 0};
  int m_a    [NI] = '{0, 0, 0};
  int m_b    [NI] = '{0, 0, 0};
  int m_err  [NI] = '{0, 0, 0};
  bit m_mis  [NI] = '{0, 0, 0};
  bit m_done [NI] = '{0, 0, 0};

  always #5 clk = ~clk;

  operand_sequencer #(.WIDTH(4), .LIMIT(10), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_i[0]), .a(a_o[0]), .b(b_o[0]),
    .busy(busy_o[0]), .mismatch(mis_o[0]), .err_cnt(err_o[0]), .done(done_o[0]));
  operand_sequencer #(.WIDTH(4), .LIMIT(1), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_i[1]), .a(a_o[1]), .b(b_o[1]),
    .busy(busy_o[1]), .mismatch(mis_o[1]), .err_cnt(err_o[1]), .done(done_o[1]));
  operand_sequencer #(.WIDTH(4), .LIMIT(16), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_i[2]), .a(a_o[2]), .b(b_o[2]),
    .busy(busy_o[2]), .mismatch(mis_o[2]), .err_cnt(err_o[2]), .done(done_o[2]));

  // Downstream adder: registered sum, with optional fault injection.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mode == 1 && a_o[k] == 4'd9 && b_o[k] == 4'd9) c_i[k] <= 4'd0;
      else if (mode == 2 && $urandom_range(7) == 0) c_i[k] <= 4'($urandom_range(15));
      else c_i[k] <= a_o[k] + b_o[k];
    end
  end

  task automatic check(input string name, input int k, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp_v);
    end
  endtask

  // Pair p occupies edges p*per .. p*per+per-1 after the start edge; its
  // operands are visible from the edge after its DRIVE and its verdict
  // appears at edge (p+1)*per. FIN is the edge LIMIT^2*per.
  task automatic model_step(input int k);
    int per, fin, p, expv;
    per = SET[k] + 2;
    fin = LIM[k] * LIM[k] * per;
    m_mis[k]  = 1'b0;
    m_done[k] = 1'b0;
    if (!rst_n) begin
      m_act[k] = 1'b0; m_a[k] = 0; m_b[k] = 0; m_err[k] = 0;
    end else if (m_act[k]) begin
      m_d[k]++;
      if (m_d[k] > fin) begin
        m_act[k] = 1'b0;
      end else begin
        if (m_d[k] % per == 0) begin
          p = m_d[k] / per - 1;
          expv = (p / LIM[k] + p % LIM[k]) % 16;
          if (int'(c_i[k]) != expv) begin
            m_mis[k] = 1'b1;
            if (m_err[k] < 255) m_err[k]++;
          end
        end
        p = (m_d[k] - 1) / per;
        m_a[k]    = p / LIM[k];
        m_b[k]    = p % LIM[k];
        m_done[k] = (m_d[k] == fin);
      end
    end else if (start) begin
      m_act[k] = 1'b1; m_d[k] = 0; m_err[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        check("a",        k, int'(a_o[k]),    m_a[k]);
        check("b",        k, int'(b_o[k]),    m_b[k]);
        check("busy",     k, int'(busy_o[k]), int'(m_act[k]));
        check("done",     k, int'(done_o[k]), int'(m_done[k]));
        check("mismatch", k, int'(mis_o[k]),  int'(m_mis[k]));
        check("err_cnt",  k, int'(err_o[k]),  m_err[k]);
      end
    end
  end

  // One start pulse, then watch until the LIMIT=16 instance finishes.
  // dcN is the cycle (counted from the start edge) in which done is high.
  task automatic sweep(input bit poke, output int dc0, output int dc1, output int dc2,
                       output int mis0, output int err0);
    dc0 = -1; dc1 = -1; dc2 = -1; mis0 = 0; err0 = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 1200 && dc2 < 0; cyc++) begin
      if (done_o[0] && dc0 < 0) begin dc0 = cyc; err0 = int'(err_o[0]); end
      if (done_o[1] && dc1 < 0) dc1 = cyc;
      if (done_o[2] && dc2 < 0) dc2 = cyc;
      if (mis_o[0]) mis0++;
      if (poke) start = (a_o[0] == 4'd2 && b_o[0] == 4'd3 && busy_o[0]);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      if (!busy_o[0] && !busy_o[1] && !busy_o[2]) ok = 1'b1;
      else @(negedge clk);
    end
    check("idle_timeout", 0, int'(ok), 1);
  endtask

  initial begin
    int dc0, dc1, dc2, mis0, err0;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_a",    0, int'(a_o[0]),    0);
    check("rst_err",  0, int'(err_o[0]),  0);
    check("rst_busy", 0, int'(busy_o[0]), 0);
    check("rst_done", 0, int'(done_o[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal adder: includes the 9+9 -> 2 wrap on instance 0.
    mode = 0;
    sweep(1'b0, dc0, dc1, dc2, mis0, err0);
    check("ideal_done_cyc",   0, dc0,  301);
    check("lim1_done_cyc",    1, dc1,  6);
    check("lim16_done_cyc",   2, dc2,  1025);
    check("ideal_err_at_done", 0, err0, 0);
    check("ideal_mis_pulses", 0, mis0, 0);
    wait_idle();

    // Adder forced to 0 on (9,9).
    mode = 1;
    sweep(1'b0, dc0, dc1, dc2, mis0, err0);
    check("fault_mis_pulses", 0, mis0, 1);
    check("fault_err_at_done", 0, err0, 1);
    check("fault_done_cyc",   0, dc0,  301);
    wait_idle();

    // Start pulsed during pair (2,3) must not disturb the sweep.
    mode = 0;
    sweep(1'b1, dc0, dc1, dc2, mis0, err0);
    check("poke_done_cyc", 0, dc0, 301);
    check("poke_err",      0, err0, 0);
    wait_idle();

    // Reset in the middle of pair (4,7).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (a_o[0] == 4'd4 && b_o[0] == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_4_7", 0, int'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_a",    0, int'(a_o[0]),    0);
    check("midrst_b",    0, int'(b_o[0]),    0);
    check("midrst_busy", 0, int'(busy_o[0]), 0);
    check("midrst_err",  0, int'(err_o[0]),  0);
    @(negedge clk);
    mode = 1;
    sweep(1'b0, dc0, dc1, dc2, mis0, err0);
    check("restart_done_cyc", 0, dc0,  301);
    check("restart_err",      0, err0, 1);
    wait_idle();

    // Random corruption, random starts and occasional resets.
    mode = 2;
    for (int n = 0; n < 15000; n++) begin
      start = ($urandom_range(99) < 3);
      rst_n = ($urandom_range(999) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
